// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory access functs, FSM states, strobe width.
// Also hosts the alignment rule used when LSU_MISALIGN_CHECK_EN is defined.
package load_store_unit_pkg;

  localparam logic [2:0] FUNCT_MEM_B  = 3'd0;
  localparam logic [2:0] FUNCT_MEM_H  = 3'd1;
  localparam logic [2:0] FUNCT_MEM_W  = 3'd2;
  localparam logic [2:0] FUNCT_MEM_BU = 3'd4;
  localparam logic [2:0] FUNCT_MEM_HU = 3'd5;

  localparam int MEM_STROBE_WIDTH = 4;
  localparam int LSU_STATE_WIDTH  = 3;

  typedef enum logic [LSU_STATE_WIDTH-1:0] {
    LSU_STATE_IDLE    = 3'd0,
    LSU_STATE_RD_ADDR = 3'd1,
    LSU_STATE_RD_DATA = 3'd2,
    LSU_STATE_WR_REQ  = 3'd3,
    LSU_STATE_WR_RESP = 3'd4,
    LSU_STATE_DONE    = 3'd5
  } lsu_state_t;

  // funct[1:0] selects the access size: 0 byte, 1 half, otherwise word.
  function automatic logic access_misaligned(input logic [2:0] funct, input logic [1:0] offset);
    case (funct[1:0])
      2'd0:    return 1'b0;
      2'd1:    return offset[0];
      default: return offset != 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Combinational byte-lane logic: store data replication and strobe generation,
// plus load lane extraction with sign/zero extension.
module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [2:0]                  funct,
  input  logic [1:0]                  offset,
  input  logic [31:0]                 store_din,
  input  logic [31:0]                 load_word,
  output logic [31:0]                 store_data,
  output logic [MEM_STROBE_WIDTH-1:0] strobe,
  output logic [31:0]                 load_result
);

  logic [31:0] shifted;

  always_comb begin
    store_data  = store_din;
    strobe      = '1;
    shifted     = load_word;
    load_result = '0;
    case (funct[1:0])
      2'd0: begin
        store_data  = {4{store_din[7:0]}};
        strobe      = 4'b0001 << offset;
        shifted     = load_word >> {offset, 3'b000};
        load_result = funct[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        // Halfword lanes only honour addr[1]; addr[0] is masked here.
        store_data  = {2{store_din[15:0]}};
        strobe      = 4'b0011 << {offset[1], 1'b0};
        shifted     = load_word >> {offset[1], 4'b0000};
        load_result = funct[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        load_result = shifted;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one bus read or write per load/store pulse, with byte lanes.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned H/W accesses complete at once with an error).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_data,
  input  logic                        store_data,
  input  logic [2:0]                  funct,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [DATA_WIDTH-1:0]       store_din,
  output logic                        data_valid,
  output logic [DATA_WIDTH-1:0]       load_dout,
  output logic                        misaligned,
  output logic                        dr_addr_valid,
  input  logic                        dr_addr_ready,
  output logic [ADDR_WIDTH-1:0]       dr_addr,
  input  logic                        dr_data_valid,
  output logic                        dr_data_ready,
  input  logic [DATA_WIDTH-1:0]       dr_data,
  output logic                        dw_valid,
  input  logic                        dw_ready,
  output logic [ADDR_WIDTH-1:0]       dw_addr,
  output logic [DATA_WIDTH-1:0]       dw_data,
  output logic [MEM_STROBE_WIDTH-1:0] dw_strobe,
  input  logic                        dw_resp_valid,
  output logic                        dw_resp_ready
);

  lsu_state_t state, state_next;

  logic [2:0]                  funct_q;
  logic [1:0]                  offset_q;
  logic                        misaligned_q;
  logic                        in_idle;
  logic                        req;
  logic                        req_misaligned;
  logic [ADDR_WIDTH-1:0]       word_addr;
  logic [2:0]                  lane_funct;
  logic [1:0]                  lane_offset;
  logic [DATA_WIDTH-1:0]       lane_store_data;
  logic [DATA_WIDTH-1:0]       lane_load_result;
  logic [MEM_STROBE_WIDTH-1:0] lane_strobe;

  assign in_idle   = (state == LSU_STATE_IDLE);
  assign req       = in_idle && (load_data || store_data);
  assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_misaligned = access_misaligned(funct, addr[1:0]);
`else
  assign req_misaligned = 1'b0;
`endif

  // The lane block serves the live request in IDLE and the captured one afterwards.
  assign lane_funct  = in_idle ? funct : funct_q;
  assign lane_offset = in_idle ? addr[1:0] : offset_q;

  lsu_lane u_lane (
    .funct       (lane_funct),
    .offset      (lane_offset),
    .store_din   (store_din),
    .load_word   (dr_data),
    .store_data  (lane_store_data),
    .strobe      (lane_strobe),
    .load_result (lane_load_result)
  );

  always_comb begin
    state_next = state;
    case (state)
      LSU_STATE_IDLE: begin
        if (store_data)     state_next = req_misaligned ? LSU_STATE_DONE : LSU_STATE_WR_REQ;
        else if (load_data) state_next = req_misaligned ? LSU_STATE_DONE : LSU_STATE_RD_ADDR;
      end
      LSU_STATE_RD_ADDR: if (dr_addr_ready) state_next = LSU_STATE_RD_DATA;
      LSU_STATE_RD_DATA: if (dr_data_valid) state_next = LSU_STATE_DONE;
      LSU_STATE_WR_REQ:  if (dw_ready)      state_next = LSU_STATE_WR_RESP;
      LSU_STATE_WR_RESP: if (dw_resp_valid) state_next = LSU_STATE_DONE;
      LSU_STATE_DONE:    state_next = LSU_STATE_IDLE;
      default:           state_next = LSU_STATE_IDLE;
    endcase
  end

  // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
  // valids are decoded from the state register so they hold, with stable payload, until then.
  assign dr_addr_valid = (state == LSU_STATE_RD_ADDR);
  assign dr_data_ready = (state == LSU_STATE_RD_DATA);
  assign dw_valid      = (state == LSU_STATE_WR_REQ);
  assign dw_resp_ready = (state == LSU_STATE_WR_RESP);
  assign data_valid    = (state == LSU_STATE_DONE);
  assign misaligned    = data_valid && misaligned_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LSU_STATE_IDLE;
      funct_q      <= '0;
      offset_q     <= '0;
      misaligned_q <= 1'b0;
      dr_addr      <= '0;
      dw_addr      <= '0;
      dw_data      <= '0;
      dw_strobe    <= '0;
      load_dout    <= '0;
    end else begin
      state <= state_next;
      if (req) begin
        funct_q      <= funct;
        offset_q     <= addr[1:0];
        misaligned_q <= req_misaligned;
        if (req_misaligned) begin
          load_dout <= '0;
        end else if (store_data) begin
          dw_addr   <= word_addr;
          dw_data   <= lane_store_data;
          dw_strobe <= lane_strobe;
        end else begin
          dr_addr <= word_addr;
        end
      end
      if (dr_data_ready && dr_data_valid) load_dout <= lane_load_result;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized loads/stores
// against a byte-addressed memory model, with a bus slave that inserts random ready/valid delays.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_data = 1'b0;
  logic        store_data = 1'b0;
  logic [2:0]  funct = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_din = 32'd0;
  logic        data_valid;
  logic [31:0] load_dout;
  logic        misaligned;
  logic        dr_addr_valid;
  logic        dr_addr_ready = 1'b0;
  logic [31:0] dr_addr;
  logic        dr_data_valid = 1'b0;
  logic        dr_data_ready;
  logic [31:0] dr_data = 32'd0;
  logic        dw_valid;
  logic        dw_ready = 1'b0;
  logic [31:0] dw_addr;
  logic [31:0] dw_data;
  logic [3:0]  dw_strobe;
  logic        dw_resp_valid = 1'b0;
  logic        dw_resp_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  kind_q[$];
  logic [7:0]  model_mem [1024];
  logic [31:0] bus_mem [256];
  int          addr_delay = 0;
  int          data_delay = 0;
  int          ra_cnt = 0, rd_cnt = 0, wa_cnt = 0, wr_cnt = 0;
  int          cur_chan = 0;
  logic [31:0] cur_addr = 32'd0;
  logic [31:0] cur_wdata = 32'd0;
  logic [3:0]  cur_strobe = 4'd0;
  logic        prev_dv = 1'b0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .store_data(store_data), .funct(funct),
    .addr(addr), .store_din(store_din), .data_valid(data_valid), .load_dout(load_dout),
    .misaligned(misaligned), .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready),
    .dr_addr(dr_addr), .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready),
    .dr_data(dr_data), .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr),
    .dw_data(dw_data), .dw_strobe(dw_strobe), .dw_resp_valid(dw_resp_valid),
    .dw_resp_ready(dw_resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_mis(input logic [2:0] f, input logic [31:0] a);
    logic half_bad, word_bad;
    half_bad = (f == FUNCT_MEM_H || f == FUNCT_MEM_HU) && a[0];
    word_bad = (f == FUNCT_MEM_W) && (a[1:0] != 2'd0);
    return MIS_EN && (half_bad || word_bad);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    logic [9:0]  b, h, w;
    logic [15:0] v16;
    b = a[9:0];
    h = {a[9:1], 1'b0};
    w = {a[9:2], 2'b00};
    v16 = {model_mem[h + 10'd1], model_mem[h]};
    case (f)
      FUNCT_MEM_B:  return {{24{model_mem[b][7]}}, model_mem[b]};
      FUNCT_MEM_BU: return {24'd0, model_mem[b]};
      FUNCT_MEM_H:  return {{16{v16[15]}}, v16};
      FUNCT_MEM_HU: return {16'd0, v16};
      default:      return {model_mem[w + 10'd3], model_mem[w + 10'd2],
                            model_mem[w + 10'd1], model_mem[w]};
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] wd, output logic [3:0] sb);
    logic [9:0] b, h, w;
    b = a[9:0];
    h = {a[9:1], 1'b0};
    w = {a[9:2], 2'b00};
    sb = 4'd0;
    case (f)
      FUNCT_MEM_B: begin
        model_mem[b] = d[7:0];
        wd = {4{d[7:0]}};
        sb[b[1:0]] = 1'b1;
      end
      FUNCT_MEM_H: begin
        model_mem[h] = d[7:0];
        model_mem[h + 10'd1] = d[15:8];
        wd = {2{d[15:0]}};
        sb[h[1:0]] = 1'b1;
        sb[h[1:0] + 2'd1] = 1'b1;
      end
      default: begin
        for (int k = 0; k < 4; k++) model_mem[w + 10'(k)] = d[8*k +: 8];
        wd = d;
        sb = 4'hF;
      end
    endcase
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    logic [9:0] w;
    w = {a[9:2], 2'b00};
    bus_mem[a[9:2]] = v;
    for (int k = 0; k < 4; k++) model_mem[w + 10'(k)] = v[8*k +: 8];
  endtask

  // ---------------- bus slave ----------------
  always @(negedge clk) begin
    if (rst) begin
      dr_addr_ready = 1'b0; dr_data_valid = 1'b0; dw_ready = 1'b0; dw_resp_valid = 1'b0;
      ra_cnt = 0; rd_cnt = 0; wa_cnt = 0; wr_cnt = 0;
    end else begin
      if (dr_addr_valid) begin
        dr_addr_ready = (ra_cnt >= addr_delay);
        if (!dr_addr_ready) ra_cnt++;
      end else begin
        dr_addr_ready = 1'b0; ra_cnt = 0;
      end
      if (dr_data_ready) begin
        dr_data_valid = (rd_cnt >= data_delay);
        if (!dr_data_valid) rd_cnt++;
      end else begin
        dr_data_valid = 1'b0; rd_cnt = 0;
      end
      dr_data = dr_data_valid ? bus_mem[dr_addr[9:2]] : $urandom();
      if (dw_valid) begin
        dw_ready = (wa_cnt >= addr_delay);
        if (!dw_ready) wa_cnt++;
      end else begin
        dw_ready = 1'b0; wa_cnt = 0;
      end
      if (dw_valid && dw_ready)
        for (int k = 0; k < 4; k++)
          if (dw_strobe[k]) bus_mem[dw_addr[9:2]][8*k +: 8] = dw_data[8*k +: 8];
      if (dw_resp_ready) begin
        dw_resp_valid = (wr_cnt >= data_delay);
        if (!dw_resp_valid) wr_cnt++;
      end else begin
        dw_resp_valid = 1'b0; wr_cnt = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    logic [1:0]  k;
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      if (dr_addr_valid) begin
        check("rd_channel", 32'(cur_chan), 32'd1);
        check("dr_addr", dr_addr, cur_addr);
      end
      if (dw_valid) begin
        check("wr_channel", 32'(cur_chan), 32'd2);
        check("dw_addr", dw_addr, cur_addr);
        check("dw_data", dw_data, cur_wdata);
        check("dw_strobe", 32'(dw_strobe), 32'(cur_strobe));
      end
      if (data_valid) begin
        check("dv_single_pulse", 32'(prev_dv), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_data_valid: got 1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          k = kind_q.pop_front();
          check("misaligned", 32'(misaligned), 32'(k[1]));
          if (k[0]) check("load_dout", load_dout, e);
        end
      end else begin
        check("misaligned_quiet", 32'(misaligned), 32'd0);
      end
      prev_dv = data_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input logic chk_lit,
                        input logic [31:0] lit_addr, input logic [31:0] lit_data,
                        input logic [3:0] lit_strobe, input logic noise);
    logic        mis, done;
    logic [31:0] wd;
    logic [3:0]  sb;
    int          n;
    @(negedge clk); #1;
    mis = model_mis(f, a);
    cur_addr = {a[31:2], 2'b00};
    if (st) begin
      cur_chan = mis ? 0 : 2;
      if (!mis) begin
        model_store(f, a, d, wd, sb);
        cur_wdata = wd;
        cur_strobe = sb;
      end
      exp_q.push_back(32'd0);
      kind_q.push_back({mis, 1'b0});
    end else begin
      cur_chan = mis ? 0 : 1;
      exp_q.push_back(mis ? 32'd0 : model_load(f, a));
      kind_q.push_back({mis, 1'b1});
    end
    load_data = ld; store_data = st; funct = f; addr = a; store_din = d;
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk); #1;
      n++;
      load_data  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      store_data = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = $urandom(); store_din = $urandom(); funct = 3'($urandom_range(0, 7));
      if (n == 1 && chk_lit && !mis) begin
        if (st) begin
          check("lit_dw_addr", dw_addr, lit_addr);
          check("lit_dw_data", dw_data, lit_data);
          check("lit_dw_strobe", 32'(dw_strobe), 32'(lit_strobe));
        end else begin
          check("lit_dr_addr", dr_addr, lit_addr);
        end
      end
      if (data_valid) begin
        done = 1'b1;
        check("latency", 32'(n), 32'(lat));
        if (chk_lit && !st) check("lit_load_dout", load_dout, lit_data);
      end
    end
    load_data = 1'b0; store_data = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: got no data_valid expected one within 100 cycles at %0t", $time);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [2:0]  fl [5];
    fl = '{FUNCT_MEM_B, FUNCT_MEM_H, FUNCT_MEM_W, FUNCT_MEM_BU, FUNCT_MEM_HU};
    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      set_word(32'(i * 4), w);
    end

    repeat (3) @(negedge clk);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_dr_addr_valid", 32'(dr_addr_valid), 32'd0);
    check("rst_dr_data_ready", 32'(dr_data_ready), 32'd0);
    check("rst_dw_valid", 32'(dw_valid), 32'd0);
    check("rst_dw_resp_ready", 32'(dw_resp_ready), 32'd0);
    check("rst_load_dout", load_dout, 32'd0);
    check("rst_dr_addr", dr_addr, 32'd0);
    check("rst_dw_addr", dw_addr, 32'd0);
    check("rst_dw_data", dw_data, 32'd0);
    check("rst_dw_strobe", 32'(dw_strobe), 32'd0);
    #1 rst = 1'b0;

    // Zero-wait directed loads and a byte store with hand-computed results.
    set_word(32'h104, 32'hDEADBEEF);
    set_word(32'h100, 32'h80112233);
    do_req(1, 0, FUNCT_MEM_W,  32'h104, 0, 3, 1, 32'h104, 32'hDEADBEEF, 0, 0);
    do_req(1, 0, FUNCT_MEM_B,  32'h103, 0, 3, 1, 32'h100, 32'hFFFFFF80, 0, 0);
    do_req(1, 0, FUNCT_MEM_BU, 32'h103, 0, 3, 1, 32'h100, 32'h00000080, 0, 0);
    do_req(1, 0, FUNCT_MEM_H,  32'h102, 0, 3, 1, 32'h100, 32'hFFFF8011, 0, 0);
    do_req(0, 1, FUNCT_MEM_B,  32'h201, 32'h000000A5, 3, 1, 32'h200, 32'hA5A5A5A5, 4'b0010, 0);

    // Stalled read with stray request pulses mid-transaction.
    addr_delay = 3; data_delay = 2;
    do_req(1, 0, FUNCT_MEM_W, 32'h104, 0, 8, 1, 32'h104, 32'hDEADBEEF, 0, 1);
    addr_delay = 0; data_delay = 0;

    // Load and store together: store wins; read it back afterwards.
    do_req(1, 1, FUNCT_MEM_W, 32'h300, 32'h12345678, 3, 1, 32'h300, 32'h12345678, 4'hF, 0);
    do_req(1, 0, FUNCT_MEM_W, 32'h300, 0, 3, 1, 32'h300, 32'h12345678, 0, 0);

    // Reset while waiting for read data.
    data_delay = 10;
    @(negedge clk); #1;
    cur_chan = 1; cur_addr = 32'h104;
    load_data = 1'b1; funct = FUNCT_MEM_W; addr = 32'h104;
    @(negedge clk); #1;
    load_data = 1'b0;
    @(negedge clk); #1;
    check("mid_rd_data_ready", 32'(dr_data_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_dr_addr_valid", 32'(dr_addr_valid), 32'd0);
    check("mid_rst_dr_data_ready", 32'(dr_data_ready), 32'd0);
    check("mid_rst_dw_valid", 32'(dw_valid), 32'd0);
    check("mid_rst_dw_resp_ready", 32'(dw_resp_ready), 32'd0);
    check("mid_rst_data_valid", 32'(data_valid), 32'd0);
    rst = 1'b0;
    data_delay = 0;

    // Misaligned word load.
`ifdef LSU_MISALIGN_CHECK_EN
    do_req(1, 0, FUNCT_MEM_W, 32'h102, 0, 1, 1, 32'h0, 32'h0, 0, 0);
`else
    do_req(1, 0, FUNCT_MEM_W, 32'h102, 0, 3, 1, 32'h100, 32'h80112233, 0, 0);
`endif

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic        ld, st;
      logic [2:0]  f;
      logic [31:0] a, d;
      int          r, lat;
      r  = $urandom_range(0, 9);
      ld = (r < 5) || (r == 9);
      st = (r >= 5);
      f  = st ? 3'($urandom_range(0, 2)) : fl[$urandom_range(0, 4)];
      a  = $urandom();
      d  = $urandom();
      addr_delay = $urandom_range(0, 3);
      data_delay = $urandom_range(0, 3);
      lat = model_mis(f, a) ? 1 : 3 + addr_delay + data_delay;
      do_req(ld, st, f, a, d, lat, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    #1;
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
